// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB master bus between NUM_REQ request/response
// ports. Grants one command at a time in round-robin order and decodes the
// slave from the top four address bits. It then runs SETUP/ACCESS with an
// optional access timeout and returns the result to the owning requester.
module apb_rr_master #(
  parameter int NUM_REQ        = 4,
  parameter int APB_NUM_SLAVES = 8,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*(APB_ADDR_WIDTH+4)-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]            req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [31:0]                      rsp_rdata,
  output logic                             rsp_err,
  output logic [APB_NUM_SLAVES-1:0]        psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [APB_ADDR_WIDTH-1:0]        paddr,
  output logic [31:0]                      pwdata,
  input  logic [APB_NUM_SLAVES*32-1:0]     prdata,
  input  logic [APB_NUM_SLAVES-1:0]        pready,
  input  logic [APB_NUM_SLAVES-1:0]        pslverr
);

  localparam int  AW    = APB_ADDR_WIDTH + 4;
  localparam int  LW    = $clog2(NUM_REQ);
  localparam int  CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   last, owner, grant_idx;
  logic            grant_found;
  logic [3:0]      slv;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   addr_arr  [NUM_REQ];
  logic [31:0]     wdata_arr [NUM_REQ];
  logic [31:0]     prdata_x  [16];
  logic [15:0]     pready_x, pslverr_x;

  logic [3:0]      grant_slv;
  logic            grant_dec_ok;
  logic            hs, access_done, timeout_hit, rsp_hs;

  // Unpack the requester buses so they can be indexed by the grant.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*32 +: 32];
  end

  // Pad the slave buses to the full 16-entry decode space; absent slaves read as idle.
  for (genvar g = 0; g < 16; g++) begin : g_slv
    if (g < APB_NUM_SLAVES) begin : g_on
      assign prdata_x[g]  = prdata[g*32 +: 32];
      assign pready_x[g]  = pready[g];
      assign pslverr_x[g] = pslverr[g];
    end else begin : g_off
      assign prdata_x[g]  = '0;
      assign pready_x[g]  = 1'b0;
      assign pslverr_x[g] = 1'b0;
    end
  end

  // Round-robin search upward from last+1 with wrap-around.
  always_comb begin : p_grant
    logic [LW:0] sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, last} + (LW+1)'(i);
      if (sum >= (LW+1)'(NUM_REQ)) sum = sum - (LW+1)'(NUM_REQ);
      if (!grant_found && req_valid[sum[LW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[LW-1:0];
      end
    end
  end

  assign grant_slv    = addr_arr[grant_idx][AW-1:APB_ADDR_WIDTH];
  assign grant_dec_ok = ({1'b0, grant_slv} < 5'(APB_NUM_SLAVES));
  assign hs           = (state == IDLE) && grant_found;
  assign access_done  = (state == ACCESS) && pready_x[slv];
  // pready in the final cycle takes priority over the timeout.
  assign timeout_hit  = TO_EN && (state == ACCESS) && !pready_x[slv] &&
                        ((int'(cnt) + 1) >= TIMEOUT_CYCLES);
  assign rsp_hs       = (state == RESP) && rsp_ready[owner];

  assign req_ready = hs ? (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign psel      = ((state == SETUP) || (state == ACCESS)) ?
                     (APB_NUM_SLAVES'(1) << slv) : '0;
  assign penable   = (state == ACCESS);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = grant_dec_ok ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, APB address/data, response capture and access counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last      <= LW'(NUM_REQ - 1);
      owner     <= '0;
      slv       <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (hs) begin
        owner <= grant_idx;
        last  <= grant_idx;
        slv   <= grant_slv;
        if (grant_dec_ok) begin
          pwrite <= req_write[grant_idx];
          paddr  <= addr_arr[grant_idx][APB_ADDR_WIDTH-1:0];
          pwdata <= wdata_arr[grant_idx];
        end else begin
          // Decode error: answer immediately, APB bus left untouched.
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state == ACCESS) begin
        if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
        if (access_done) begin
          rsp_rdata <= pwrite ? 32'd0 : prdata_x[slv];
          rsp_err   <= pslverr_x[slv];
        end else if (timeout_hit) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (rsp_hs) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed and randomized transfers against a
// transaction-level model (round-robin pointer, slave data table, timeout rule).
module tb_apb_rr_master;

  localparam int NR = 4;
  localparam int NS = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NR-1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [NR*16-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
  logic [NS-1:0]  psel;
  logic           penable, pwrite;
  logic [11:0]    paddr;
  logic [31:0]    pwdata;
  logic [NS*32-1:0] prdata;
  logic [NS-1:0]  pready, pslverr;

  apb_rr_master #(
    .NUM_REQ(NR), .APB_NUM_SLAVES(NS), .APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester command table
  logic        w_r [NR];
  logic [15:0] a_r [NR];
  logic [31:0] d_r [NR];

  // Slave model: selected slave answers after wait_n extra ACCESS cycles
  logic [31:0] slv_data [NS];
  int  acc = 0;
  int  wait_n = 0;
  bit  never = 1'b1;
  bit  serr = 1'b0;
  int  exp_slv = 0;
  int  model_last = NR - 1;

  always @(posedge clk) begin
    if (penable === 1'b1) acc <= acc + 1;
    else                  acc <= 0;
  end

  always_comb begin
    pready  = '0;
    pslverr = '0;
    for (int s = 0; s < NS; s++) prdata[s*32 +: 32] = slv_data[s];
    if (!never && acc == wait_n) begin
      pready[exp_slv]  = 1'b1;
      pslverr[exp_slv] = serr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input int lst, input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (lst + k) % NR;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic pack_reqs();
    for (int r = 0; r < NR; r++) begin
      req_write[r]           = w_r[r];
      req_addr[r*16 +: 16]   = a_r[r];
      req_wdata[r*32 +: 32]  = d_r[r];
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // One complete transfer: grant check, APB phases, response and hold.
  task automatic xfer(input logic [NR-1:0] mask, input int waitc, input bit nev,
                      input bit se, input int hold);
    int g, slv, n, cyc, exp_n;
    bit dec, to, stab, hold_ok;
    logic [31:0] exp_rd, rd0;
    logic exp_err, e0;
    g = rr(model_last, mask);
    model_last = g;
    slv = int'(a_r[g][15:12]);
    dec = (slv >= NS);
    to  = !dec && (nev || (waitc + 1 > TO));
    exp_n   = dec ? 0 : (to ? TO : waitc + 1);
    exp_err = dec || to || se;
    exp_rd  = (dec || to || w_r[g]) ? 32'd0 : slv_data[slv];
    exp_slv = dec ? 0 : slv;
    wait_n  = waitc;
    never   = dec || nev;
    serr    = se;
    pack_reqs();
    req_valid = mask;
    #1;
    chk("grant", req_ready, 4'b1 << g);
    @(negedge clk);
    req_valid[g] = 1'b0;
    cyc = 1; n = 0; stab = 1'b1;
    if (!dec) begin
      chk("setup_psel", psel, 8'b1 << slv);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, a_r[g][11:0]);
      chk("setup_pwrite", pwrite, w_r[g]);
      chk("setup_pwdata", pwdata, d_r[g]);
      chk("busy_req_ready", req_ready, 0);
      while (cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (rsp_valid !== 4'b0) break;
        n++;
        if (psel !== (8'b1 << slv) || penable !== 1'b1 || paddr !== a_r[g][11:0] ||
            pwrite !== w_r[g] || pwdata !== d_r[g] || req_ready !== 4'b0) stab = 1'b0;
      end
      chk("access_stable", stab, 1);
      chk("access_cycles", n, exp_n);
    end else begin
      chk("dec_psel", psel, 0);
    end
    chk("latency", cyc, dec ? 1 : 2 + exp_n);
    chk("rsp_valid", rsp_valid, 4'b1 << g);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("resp_penable", penable, 0);
    chk("resp_psel", psel, 0);
    rd0 = rsp_rdata; e0 = rsp_err; hold_ok = 1'b1;
    rsp_ready = ~(4'b1 << g);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (rsp_valid !== (4'b1 << g) || rsp_rdata !== rd0 || rsp_err !== e0) hold_ok = 1'b0;
    end
    if (hold > 0) chk("rsp_hold", hold_ok, 1);
    rsp_ready = 4'b1 << g;
    req_valid = '0;
    @(negedge clk);
    chk("rsp_done", rsp_valid, 0);
    rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rstn = 1'b0; req_valid = '0; rsp_ready = '0; req_write = '0;
    req_addr = '0; req_wdata = '0;
    for (int s = 0; s < NS; s++) slv_data[s] = $urandom;
    slv_data[2] = 32'h1234_5678;
    for (int r = 0; r < NR; r++) begin w_r[r] = 1'b0; a_r[r] = '0; d_r[r] = '0; end
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Round-robin with every requester issuing writes: grants 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      for (int r = 0; r < NR; r++) begin
        w_r[r] = 1'b1;
        a_r[r] = {4'(r + 1), 12'($urandom)};
        d_r[r] = $urandom;
      end
      chk("rr_order", rr(model_last, 4'hF), t % NR);
      xfer(4'hF, 0, 0, 0, 0);
    end

    // Zero-wait read of slave 2.
    w_r[0] = 1'b0; a_r[0] = 16'h20A4; d_r[0] = 32'h0;
    xfer(4'b0001, 0, 0, 0, 0);

    // Write to slave 5, three wait states then slave error.
    w_r[2] = 1'b1; a_r[2] = 16'h5123; d_r[2] = 32'hCAFE_F00D;
    xfer(4'b0100, 3, 0, 1, 0);

    // Decode error: slave index 0xA.
    w_r[3] = 1'b0; a_r[3] = 16'hA010; d_r[3] = 32'h0;
    xfer(4'b1000, 0, 0, 0, 0);

    // Timeout, then pready exactly on the final allowed cycle.
    w_r[1] = 1'b0; a_r[1] = 16'h6400; d_r[1] = 32'h0;
    xfer(4'b0010, 0, 1, 0, 0);
    xfer(4'b0010, TO - 1, 0, 0, 0);

    // Response held for five cycles before acceptance.
    w_r[0] = 1'b0; a_r[0] = 16'h1ABC;
    xfer(4'b0001, 1, 0, 0, 5);

    // Reset asserted in the middle of ACCESS.
    w_r[1] = 1'b1; a_r[1] = 16'h3123; d_r[1] = 32'h5555_AAAA;
    exp_slv = 3; never = 1'b1;
    pack_reqs();
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("pre_reset_penable", penable, 1);
    rstn = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_last = NR - 1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0 || psel !== 8'b0) ok = 1'b0;
    end
    chk("no_rsp_after_reset", ok, 1);
    for (int r = 0; r < NR; r++) begin
      w_r[r] = 1'($urandom); a_r[r] = {4'(r), 12'($urandom)}; d_r[r] = $urandom;
    end
    xfer(4'hF, 0, 0, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < NR; r++) begin
        w_r[r] = 1'($urandom);
        a_r[r] = {4'($urandom_range(0, 9)), 12'($urandom)};
        d_r[r] = $urandom;
      end
      xfer(4'($urandom_range(1, 15)), $urandom_range(0, 4), 0,
           1'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
